// File: rtl/regfile_writeback.sv
// Register-file write-port front end: merges ALU and queued load results into one write per cycle.
// Latency: ALU result written 1 cycle after acceptance; load written >=1 cycle after enqueue.
// Backpressure: alu_ready drops for one forced-drain cycle; load_ready drops when the load FIFO is full.

// Small synchronous FIFO with registered occupancy; no pass-through when full.
// Latency: entry visible at the head one cycle after push.
// Backpressure: in_rdy = (count < DEPTH), low while reset is asserted.
module regfile_writeback_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [W-1:0]  in_dat,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [W-1:0]  out_dat,
    output logic [CW-1:0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push;
    logic          pop;

    assign in_rdy  = rst_n && (count_q < CW'(DEPTH));
    assign out_vld = (count_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Pointer, occupancy and storage next-state; pointers wrap naturally at a power-of-2 depth.
    always_comb begin
        mem_d    = mem_q;
        push     = in_vld && in_rdy;
        pop      = out_rdy && out_vld;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        if (push) begin
            mem_d[wr_ptr_q] = in_dat;
        end
    end

    // FIFO state registers; reset discards all contents.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end
endmodule

module regfile_writeback #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk_in,
    input  logic                     rst_n,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_rd,
    input  logic [31:0]              alu_data,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [4:0]               load_rd,
    input  logic [31:0]              load_data,
    input  logic                     issue_valid,
    input  logic [4:0]               issue_rd,
    output logic                     write_enable,
    output logic [4:0]               write_address,
    output logic [31:0]              write_data,
    output logic [31:0]              pending_mask,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] dat;
    } wb_t;

    typedef enum logic {ST_NORMAL, ST_FORCE} state_t;

    state_t        state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] cnt_inc;
    logic          we_q, we_d;
    logic [4:0]    waddr_q, waddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   mask_q, mask_d;

    logic          alu_xfer;
    logic          deq;
    logic          win;
    wb_t           win_ent;
    wb_t           load_ent;
    wb_t           head_ent;
    logic          fifo_nonempty;
    logic [CW-1:0] count;

    assign load_ent  = '{rd: load_rd, dat: load_data};
    assign alu_ready = rst_n && (state_q == ST_NORMAL);
    assign alu_xfer  = alu_valid && alu_ready;
    assign cnt_inc   = cnt_q + 1'b1;

    regfile_writeback_fifo #(
        .W     ($bits(wb_t)),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_load_fifo (
        .clk_in  (clk_in),
        .rst_n   (rst_n),
        .in_vld  (load_valid),
        .in_rdy  (load_ready),
        .in_dat  (load_ent),
        .out_vld (fifo_nonempty),
        .out_rdy (deq),
        .out_dat (head_ent),
        .count   (count)
    );

    // Write-slot arbitration and starvation FSM: ALU wins unless a forced load drain is due.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deq     = 1'b0;
        win     = 1'b0;
        win_ent = '0;
        case (state_q)
            ST_NORMAL: begin
                if (alu_xfer) begin
                    win     = 1'b1;
                    win_ent = '{rd: alu_rd, dat: alu_data};
                end else if (fifo_nonempty) begin
                    deq     = 1'b1;
                    win     = 1'b1;
                    win_ent = head_ent;
                end
                // Only ALU wins that leave a waiting load behind count toward starvation.
                if (!fifo_nonempty || deq) begin
                    cnt_d = '0;
                end else if (alu_xfer) begin
                    if (cnt_inc == SW'(STARVE_LIMIT)) begin
                        state_d = ST_FORCE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            ST_FORCE: begin
                deq     = fifo_nonempty;
                win     = fifo_nonempty;
                win_ent = head_ent;
                state_d = ST_NORMAL;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_NORMAL;
                cnt_d   = '0;
            end
        endcase
    end

    // Registered write port and pending-destination scoreboard (a new issue beats a same-edge clear).
    always_comb begin
        we_d    = win && (win_ent.rd != 5'd0);
        waddr_d = win ? win_ent.rd  : waddr_q;
        wdata_d = win ? win_ent.dat : wdata_q;
        mask_d  = mask_q;
        if (we_q) begin
            mask_d[waddr_q] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            mask_d[issue_rd] = 1'b1;
        end
    end

    // State registers; reset also drops any in-flight write.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_NORMAL;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
        end
    end

    assign write_enable  = we_q;
    assign write_address = waddr_q;
    assign write_data    = wdata_q;
    assign pending_mask  = mask_q;
    assign fifo_count    = count;
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model advances on each rising edge; outputs compared on the falling edge.
// Backpressure: producers hold rd/data until the model sees the transfer.
module tb_regfile_writeback;
    localparam int DEPTH = 4;
    localparam int LIMIT = 4;

    logic        clk_in = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        load_valid, load_ready;
    logic [4:0]  load_rd;
    logic [31:0] load_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        write_enable;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    regfile_writeback #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk_in        (clk_in),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_rd        (alu_rd),
        .alu_data      (alu_data),
        .load_valid    (load_valid),
        .load_ready    (load_ready),
        .load_rd       (load_rd),
        .load_data     (load_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .write_enable  (write_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .pending_mask  (pending_mask),
        .fifo_count    (fifo_count)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;
    logic cmp_on = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of waiting loads plus the forced-drain rule.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] dat;
    } ent_t;

    ent_t        q[$];
    logic        m_we, m_force, m_alu_took, m_load_took;
    logic [4:0]  m_wa;
    logic [31:0] m_wd, m_mask;
    int          m_starve;

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_we = 0; m_wa = 0; m_wd = 0; m_mask = 0;
            m_force = 0; m_starve = 0; m_alu_took = 0; m_load_took = 0;
        end else begin
            logic   nonempty, popped, has_w, alu_x, load_x;
            ent_t   w;
            nonempty = (q.size() != 0);
            alu_x    = alu_valid && !m_force;
            load_x   = load_valid && (q.size() < DEPTH);
            popped   = 0;
            has_w    = 0;
            w        = '{rd: 0, dat: 0};
            if (alu_x) begin
                w = '{rd: alu_rd, dat: alu_data};
                has_w = 1;
            end else if (nonempty) begin
                w = q.pop_front();
                popped = 1;
                has_w = 1;
            end
            if (m_we) m_mask[m_wa] = 1'b0;
            if (issue_valid && issue_rd != 0) m_mask[issue_rd] = 1'b1;
            if (has_w) begin
                m_we = (w.rd != 0);
                m_wa = w.rd;
                m_wd = w.dat;
            end else begin
                m_we = 0;
            end
            if (m_force) begin
                m_force = 0;
                m_starve = 0;
            end else if (!nonempty || popped) begin
                m_starve = 0;
            end else if (alu_x) begin
                m_starve++;
                if (m_starve == LIMIT) begin
                    m_force = 1;
                    m_starve = 0;
                end
            end
            if (load_x) q.push_back('{rd: load_rd, dat: load_data});
            m_alu_took  = alu_x;
            m_load_took = load_x;
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk_in) begin
        if (rst_n && cmp_on) begin
            chk("write_enable", 32'(write_enable), 32'(m_we));
            chk("write_address", 32'(write_address), 32'(m_wa));
            chk("write_data", write_data, m_wd);
            chk("pending_mask", pending_mask, m_mask);
            chk("alu_ready", 32'(alu_ready), 32'(!m_force));
            chk("load_ready", 32'(load_ready), 32'(q.size() < DEPTH));
            chk("fifo_count", 32'(fifo_count), 32'(q.size()));
        end
    end

    logic [31:0] snap;
    int          nl;
    logic        seen_full;
    logic [4:0]  la[$];

    initial begin
        rst_n = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        load_valid = 0; load_rd = 0; load_data = 0; issue_valid = 0; issue_rd = 0;
        repeat (2) @(negedge clk_in);
        chk("rst_we", 32'(write_enable), 0);
        chk("rst_addr", 32'(write_address), 0);
        chk("rst_data", write_data, 0);
        chk("rst_mask", pending_mask, 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_alu_rdy", 32'(alu_ready), 0);
        chk("rst_load_rdy", 32'(load_ready), 0);
        rst_n = 1; cmp_on = 1;
        @(negedge clk_in);
        chk("post_rst_alu_rdy", 32'(alu_ready), 1);
        chk("post_rst_load_rdy", 32'(load_ready), 1);

        // ALU path and scoreboard set/clear for r5.
        issue_valid = 1; issue_rd = 5;
        @(negedge clk_in);
        issue_valid = 0;
        chk("t2_pend5_set", 32'(pending_mask[5]), 1);
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        @(negedge clk_in);
        alu_valid = 0;
        chk("t2_we", 32'(write_enable), 1);
        chk("t2_addr", 32'(write_address), 5);
        chk("t2_data", write_data, 32'hDEADBEEF);
        @(negedge clk_in);
        chk("t2_pend5_clr", 32'(pending_mask[5]), 0);

        // x0 result consumes the slot without a write.
        snap = pending_mask;
        chk("t5_alu_rdy", 32'(alu_ready), 1);
        alu_valid = 1; alu_rd = 0; alu_data = 32'h1234;
        @(negedge clk_in);
        alu_valid = 0;
        chk("t5_we", 32'(write_enable), 0);
        chk("t5_data", write_data, 32'h1234);
        chk("t5_mask", pending_mask, snap);

        // Same-edge set and clear of r9: set wins.
        issue_valid = 1; issue_rd = 9;
        @(negedge clk_in);
        issue_valid = 0;
        alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
        @(negedge clk_in);
        alu_valid = 0;
        chk("t6_we", 32'(write_enable), 1);
        chk("t6_addr", 32'(write_address), 9);
        issue_valid = 1; issue_rd = 9;
        @(negedge clk_in);
        issue_valid = 0;
        chk("t6_pend9", 32'(pending_mask[9]), 1);

        // Starvation: one load waits behind four ALU wins, then is forced out.
        load_valid = 1; load_rd = 7; load_data = 32'h0007_0007;
        @(negedge clk_in);
        load_valid = 0;
        chk("t4_count", 32'(fifo_count), 1);
        for (int i = 0; i < LIMIT; i++) begin
            chk("t4_alu_rdy", 32'(alu_ready), 1);
            alu_valid = 1; alu_rd = 5'(10 + i); alu_data = 32'(i);
            @(negedge clk_in);
        end
        chk("t4_force_rdy", 32'(alu_ready), 0);
        chk("t4_last_alu", 32'(write_address), 13);
        alu_rd = 14; alu_data = 32'h14;
        @(negedge clk_in);
        chk("t4_load_we", 32'(write_enable), 1);
        chk("t4_load_addr", 32'(write_address), 7);
        chk("t4_load_data", write_data, 32'h0007_0007);
        chk("t4_resume_rdy", 32'(alu_ready), 1);
        @(negedge clk_in);
        alu_valid = 0;
        chk("t4_resume_addr", 32'(write_address), 14);
        @(negedge clk_in);

        // FIFO fills under ALU saturation; forced drains keep load order.
        nl = 0; seen_full = 0;
        for (int c = 0; c < 40; c++) begin
            if (load_valid && m_load_took) load_valid = 0;
            if (!load_valid && nl < 4) begin
                nl++;
                load_valid = 1; load_rd = 5'(nl); load_data = 32'(32'h100 + nl);
            end
            if (write_enable && write_address >= 1 && write_address <= 4) la.push_back(write_address);
            if (fifo_count == 3'd4 && !seen_full) begin
                seen_full = 1;
                chk("t3_full_rdy", 32'(load_ready), 0);
            end
            if (!alu_valid || m_alu_took) begin
                alu_valid = 1; alu_rd = 5'(16 + (c % 16)); alu_data = 32'($urandom);
            end
            @(negedge clk_in);
        end
        alu_valid = 0; load_valid = 0;
        chk("t3_seen_full", 32'(seen_full), 1);
        chk("t3_nloads", 32'(la.size()), 4);
        for (int i = 0; i < 4 && i < la.size(); i++) chk("t3_order", 32'(la[i]), 32'(i + 1));
        repeat (3) @(negedge clk_in);

        // Reset in the middle of traffic with three loads queued.
        for (int c = 0; c < 3; c++) begin
            load_valid = 1; load_rd = 5'(20 + c); load_data = 32'(c);
            alu_valid = 1; alu_rd = 5'(c + 1); alu_data = 32'hA000 + 32'(c);
            @(negedge clk_in);
        end
        chk("t1_count3", 32'(fifo_count), 3);
        #2 rst_n = 0;
        alu_valid = 0; load_valid = 0;
        #1;
        chk("t1_we", 32'(write_enable), 0);
        chk("t1_addr", 32'(write_address), 0);
        chk("t1_data", write_data, 0);
        chk("t1_mask", pending_mask, 0);
        chk("t1_count", 32'(fifo_count), 0);
        chk("t1_alu_rdy", 32'(alu_ready), 0);
        chk("t1_load_rdy", 32'(load_ready), 0);
        @(negedge clk_in);
        rst_n = 1;
        @(negedge clk_in);
        chk("t1_after_count", 32'(fifo_count), 0);
        chk("t1_after_load_rdy", 32'(load_ready), 1);

        // Randomized traffic; producers hold until their transfer is seen.
        for (int c = 0; c < 3000; c++) begin
            if (!alu_valid || m_alu_took) begin
                alu_valid = ($urandom_range(3) != 0);
                alu_rd = 5'($urandom); alu_data = $urandom;
            end
            if (!load_valid || m_load_took) begin
                load_valid = ($urandom_range(2) == 0);
                load_rd = 5'($urandom); load_data = $urandom;
            end
            issue_valid = $urandom_range(1) == 1;
            issue_rd = 5'($urandom);
            @(negedge clk_in);
        end
        alu_valid = 0; load_valid = 0; issue_valid = 0;
        repeat (30) @(negedge clk_in);
        cmp_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
